// File: rtl/saxis_rr_arbiter.sv
// rtl/saxis_rr_arbiter.sv - packet-granular round-robin AXI-Stream arbiter with registered output
module saxis_rr_arbiter #(
   parameter int NUM_SI = 4,
   parameter int WIDTH  = 32,
   localparam int IW    = (NUM_SI > 1) ? $clog2(NUM_SI) : 1,
   localparam int KW    = WIDTH / 8
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [NUM_SI-1:0]      en_mask,
   input  logic [NUM_SI*WIDTH-1:0] S_AXIS_TDATA,
   input  logic [NUM_SI-1:0]      S_AXIS_TVALID,
   output logic [NUM_SI-1:0]      S_AXIS_TREADY,
   input  logic [NUM_SI-1:0]      S_AXIS_TLAST,
   input  logic [NUM_SI*KW-1:0]   S_AXIS_TKEEP,
   input  logic [NUM_SI*KW-1:0]   S_AXIS_TSTRB,
   output logic [WIDTH-1:0]       M_AXIS_TDATA,
   output logic                   M_AXIS_TVALID,
   input  logic                   M_AXIS_TREADY,
   output logic                   M_AXIS_TLAST,
   output logic [KW-1:0]          M_AXIS_TKEEP,
   output logic [KW-1:0]          M_AXIS_TSTRB,
   output logic [IW-1:0]          grant_idx,
   output logic                   busy
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     grant_idx_q, grant_idx_d;
   logic [IW-1:0]     last_grant_q, last_grant_d;
   logic              tvalid_q, tvalid_d;
   logic [WIDTH-1:0]  tdata_q, tdata_d;
   logic              tlast_q, tlast_d;
   logic [KW-1:0]     tkeep_q, tkeep_d;
   logic [KW-1:0]     tstrb_q, tstrb_d;

   logic [NUM_SI-1:0] req;
   logic [IW-1:0]     winner;
   logic              out_ready;
   logic              accept;
   logic              sel_valid;
   logic              sel_last;
   logic [WIDTH-1:0]  sel_data;
   logic [KW-1:0]     sel_keep;
   logic [KW-1:0]     sel_strb;

   // Output slot can take a beat when empty or being drained this cycle
   assign out_ready = M_AXIS_TREADY | ~tvalid_q;
   assign req       = S_AXIS_TVALID & en_mask;

   // Steer the granted port's stream signals onto a single set of wires
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      sel_strb  = '0;
      for (int i = 0; i < NUM_SI; i++) begin
         if (grant_idx_q == IW'(i)) begin
            sel_valid = S_AXIS_TVALID[i];
            sel_last  = S_AXIS_TLAST[i];
            sel_data  = S_AXIS_TDATA[i*WIDTH +: WIDTH];
            sel_keep  = S_AXIS_TKEEP[i*KW +: KW];
            sel_strb  = S_AXIS_TSTRB[i*KW +: KW];
         end
      end
   end

   // Rotating search; iterating farthest-first lets the nearest requester overwrite
   always_comb begin
      int idx;
      idx    = 0;
      winner = last_grant_q;
      for (int k = NUM_SI; k >= 1; k--) begin
         idx = (int'(last_grant_q) + k) % NUM_SI;
         if (req[idx]) begin
            winner = IW'(idx);
         end
      end
   end

   // Only the owning port sees ready, and only while the output slot can accept
   always_comb begin
      S_AXIS_TREADY = '0;
      if (state_q == BUSY) begin
         for (int i = 0; i < NUM_SI; i++) begin
            if (grant_idx_q == IW'(i)) begin
               S_AXIS_TREADY[i] = out_ready;
            end
         end
      end
   end

   assign accept = (state_q == BUSY) & sel_valid & out_ready;

   // Next-state for grant FSM and output register
   always_comb begin
      state_d      = state_q;
      grant_idx_d  = grant_idx_q;
      last_grant_d = last_grant_q;
      tvalid_d     = tvalid_q;
      tdata_d      = tdata_q;
      tlast_d      = tlast_q;
      tkeep_d      = tkeep_q;
      tstrb_d      = tstrb_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d      = BUSY;
               grant_idx_d  = winner;
               last_grant_d = winner;
            end
         end
         BUSY: begin
            if (accept && sel_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         tvalid_d = 1'b1;
         tdata_d  = sel_data;
         tlast_d  = sel_last;
         tkeep_d  = sel_keep;
         tstrb_d  = sel_strb;
      end else if (M_AXIS_TREADY) begin
         tvalid_d = 1'b0;
      end
   end

   // State registers; reset leaves port 0 with first priority
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         grant_idx_q  <= '0;
         last_grant_q <= IW'(NUM_SI - 1);
         tvalid_q     <= 1'b0;
         tdata_q      <= '0;
         tlast_q      <= 1'b0;
         tkeep_q      <= '0;
         tstrb_q      <= '0;
      end else begin
         state_q      <= state_d;
         grant_idx_q  <= grant_idx_d;
         last_grant_q <= last_grant_d;
         tvalid_q     <= tvalid_d;
         tdata_q      <= tdata_d;
         tlast_q      <= tlast_d;
         tkeep_q      <= tkeep_d;
         tstrb_q      <= tstrb_d;
      end
   end

   assign M_AXIS_TVALID = tvalid_q;
   assign M_AXIS_TDATA  = tdata_q;
   assign M_AXIS_TLAST  = tlast_q;
   assign M_AXIS_TKEEP  = tkeep_q;
   assign M_AXIS_TSTRB  = tstrb_q;
   assign grant_idx     = grant_idx_q;
   assign busy          = (state_q == BUSY);

endmodule

// File: tb/tb_saxis_rr_arbiter.sv
// tb/tb_saxis_rr_arbiter.sv - randomized model-checked bench for saxis_rr_arbiter
module tb_saxis_rr_arbiter;
   localparam int N = 4;
   localparam int W = 32;
   localparam int K = W / 8;

   logic             aclk = 1'b0;
   logic             aresetn;
   logic [N-1:0]     en_mask;
   logic [N*W-1:0]   s_tdata;
   logic [N-1:0]     s_tvalid;
   logic [N-1:0]     s_tready;
   logic [N-1:0]     s_tlast;
   logic [N*K-1:0]   s_tkeep;
   logic [N*K-1:0]   s_tstrb;
   logic [W-1:0]     m_tdata;
   logic             m_tvalid;
   logic             m_tready;
   logic             m_tlast;
   logic [K-1:0]     m_tkeep;
   logic [K-1:0]     m_tstrb;
   logic [1:0]       grant_idx;
   logic             busy;

   always #5 aclk = ~aclk;

   saxis_rr_arbiter #(.NUM_SI(N), .WIDTH(W)) dut (
      .aclk(aclk), .aresetn(aresetn), .en_mask(en_mask),
      .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
      .S_AXIS_TLAST(s_tlast), .S_AXIS_TKEEP(s_tkeep), .S_AXIS_TSTRB(s_tstrb),
      .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
      .M_AXIS_TLAST(m_tlast), .M_AXIS_TKEEP(m_tkeep), .M_AXIS_TSTRB(m_tstrb),
      .grant_idx(grant_idx), .busy(busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: owner of the output, rotating pointer, one-slot output buffer
   bit           mb;
   int           mg;
   int           ml;
   bit           mov;
   logic [W-1:0] mod;
   bit           mol;
   logic [K-1:0] mok;
   logic [K-1:0] mos;
   logic [N-1:0] exp_tr;
   logic [N-1:0] acc;

   int rem [N];
   int seq [N];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      mb = 0; mg = 0; ml = N - 1;
      mov = 0; mod = '0; mol = 0; mok = '0; mos = '0;
   endtask

   // One cycle: inputs already driven at negedge; check, advance model, move to next negedge
   task automatic step();
      bit           ordy;
      bit           found;
      int           p;
      logic [N-1:0] req;
      #1;
      ordy   = m_tready || !mov;
      exp_tr = '0;
      if (mb && ordy) exp_tr[mg] = 1'b1;
      chk("m_tvalid", 32'(m_tvalid), 32'(mov));
      chk("m_tdata",  m_tdata, mod);
      chk("m_tlast",  32'(m_tlast), 32'(mol));
      chk("m_tkeep",  32'(m_tkeep), 32'(mok));
      chk("m_tstrb",  32'(m_tstrb), 32'(mos));
      chk("s_tready", 32'(s_tready), 32'(exp_tr));
      chk("busy",     32'(busy), 32'(mb));
      chk("grant_idx", 32'(grant_idx), 32'(mg));
      acc = '0;
      if (!aresetn) begin
         model_reset();
      end else if (!mb) begin
         req   = s_tvalid & en_mask;
         found = 0;
         for (int k = 1; k <= N; k++) begin
            p = (ml + k) % N;
            if (!found && req[p]) begin
               found = 1; mb = 1; mg = p; ml = p;
            end
         end
         if (m_tready) mov = 0;
      end else if (s_tvalid[mg] && ordy) begin
         acc[mg] = 1'b1;
         mov = 1;
         mod = s_tdata[mg*W +: W];
         mol = s_tlast[mg];
         mok = s_tkeep[mg*K +: K];
         mos = s_tstrb[mg*K +: K];
         if (mol) mb = 0;
      end else if (m_tready) begin
         mov = 0;
      end
      @(posedge aclk);
      @(negedge aclk);
   endtask

   // Producers hold each beat until accepted, then maybe present the next one
   task automatic drive_prod(input int pct);
      for (int i = 0; i < N; i++) begin
         if (!s_tvalid[i] && $urandom_range(99) < pct) begin
            if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
            s_tvalid[i]           = 1'b1;
            s_tdata[i*W +: W]     = {8'(i), 8'h5A, 16'(seq[i])};
            s_tlast[i]            = (rem[i] == 1);
            s_tkeep[i*K +: K]     = K'($urandom);
            s_tstrb[i*K +: K]     = K'($urandom);
         end
      end
   endtask

   task automatic consume();
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            s_tvalid[i] = 1'b0;
            rem[i]--;
            seq[i]++;
         end
      end
   endtask

   initial begin
      int b;
      int phase;
      int pct;
      aresetn  = 1'b0;
      en_mask  = '1;
      m_tready = 1'b1;
      s_tvalid = '0;
      s_tdata  = '0;
      s_tlast  = '0;
      s_tkeep  = '0;
      s_tstrb  = '0;
      for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; end
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      model_reset();
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_tdata", m_tdata, 32'd0);
      chk("rst_grant", 32'(grant_idx), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tready", 32'(s_tready), 32'd0);

      // Single 3-beat packet on port 2
      aresetn = 1'b1;
      b = 0;
      s_tvalid[2] = 1'b1;
      s_tdata[2*W +: W] = 32'hA0;
      s_tlast[2] = 1'b0;
      s_tkeep[2*K +: K] = '1;
      s_tstrb[2*K +: K] = '1;
      for (int c = 1; c <= 6; c++) begin
         step();
         if (acc[2]) begin
            b++;
            if (b == 3) s_tvalid[2] = 1'b0;
            else begin
               s_tdata[2*W +: W] = 32'hA0 + 32'(b);
               s_tlast[2] = (b == 2);
            end
         end
         case (c)
            1: begin chk("pkt_busy1", 32'(busy), 32'd1); chk("pkt_grant", 32'(grant_idx), 32'd2); end
            2: begin chk("pkt_v2", 32'(m_tvalid), 32'd1); chk("pkt_d0", m_tdata, 32'hA0); end
            3: chk("pkt_d1", m_tdata, 32'hA1);
            4: begin
               chk("pkt_d2", m_tdata, 32'hA2);
               chk("pkt_last", 32'(m_tlast), 32'd1);
               chk("pkt_busy0", 32'(busy), 32'd0);
            end
            5: chk("pkt_drain", 32'(m_tvalid), 32'd0);
            default: ;
         endcase
      end

      // Reset restores port 0 priority over port 3
      aresetn = 1'b0;
      step();
      aresetn = 1'b1;
      s_tvalid = 4'b1001;
      s_tlast  = 4'b1001;
      step();
      chk("rst_prio_grant", 32'(grant_idx), 32'd0);
      aresetn  = 1'b0;
      s_tvalid = '0;
      s_tlast  = '0;
      step();
      aresetn = 1'b1;

      // Randomized phases: fairness, mask, backpressure, mid-packet reset
      for (int cyc = 0; cyc < 3000; cyc++) begin
         phase = cyc / 750;
         pct = 100;
         case (phase)
            0: begin en_mask = '1; m_tready = 1'b1; pct = 100; end
            1: begin en_mask = {1'b1, 1'b0, ($urandom_range(99) < 90), 1'b0}; m_tready = 1'b1; pct = 90; end
            default: begin
               if ($urandom_range(19) == 0) en_mask = N'($urandom);
               m_tready = 1'($urandom);
               pct = 60;
            end
         endcase
         aresetn = !(phase == 3 && $urandom_range(99) == 0);
         if (!aresetn) begin
            s_tvalid = '0;
            for (int i = 0; i < N; i++) rem[i] = 0;
         end else begin
            drive_prod(pct);
         end
         step();
         consume();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
